// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared types, default latencies and op-class helpers for the
//               multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  localparam int MDU_WIDTH_DEF   = 32;
  localparam int MDU_MUL_LAT_DEF = 5;
  localparam int MDU_DIV_LAT_DEF = 10;

  typedef enum logic [3:0] {
    MDU_MULTU = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_DIVU  = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_MADDU = 4'd4,
    MDU_MADD  = 4'd5,
    MDU_MSUBU = 4'd6,
    MDU_MSUB  = 4'd7
  } mdu_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_t;

  function automatic logic is_div(input mdu_op_t op);
    return (op == MDU_DIVU) || (op == MDU_DIV);
  endfunction

  function automatic logic is_signed(input mdu_op_t op);
    return (op == MDU_MULT) || (op == MDU_DIV) || (op == MDU_MADD) || (op == MDU_MSUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
// Module      : mdu_arith
// Description : Combinational result datapath. Maps the latched op/operands
//               and current {HI,LO} to the next {HI,LO}; upd_o is low when
//               HI/LO must stay unchanged (divide by zero).
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH_DEF
) (
  input  mdu_op_t          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             upd_o
);

  localparam int W2 = 2 * WIDTH;

  logic             sgn, a_neg, b_neg;
  logic [W2-1:0]    a_ext, b_ext, prod, acc;
  logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s;

  // Products are formed on sign/zero-extended operands so the low 2*WIDTH bits
  // are correct for both signednesses; division works on magnitudes, then the
  // quotient takes the XOR of signs and the remainder the dividend's sign.
  // The overflow case (-2^(W-1) / -1) falls out naturally as -2^(W-1) rem 0.
  always_comb begin
    sgn   = is_signed(op_i);
    a_neg = sgn & a_i[WIDTH-1];
    b_neg = sgn & b_i[WIDTH-1];
    a_ext = {{WIDTH{a_neg}}, a_i};
    b_ext = {{WIDTH{b_neg}}, b_i};
    prod  = a_ext * b_ext;
    acc   = {hi_i, lo_i};
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;
    if (b_mag == '0) begin
      q_mag = '0;
      r_mag = '0;
    end else begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    q_s = (a_neg ^ b_neg) ? -q_mag : q_mag;
    r_s = a_neg ? -r_mag : r_mag;

    hi_o  = hi_i;
    lo_o  = lo_i;
    upd_o = 1'b1;
    case (op_i)
      MDU_MULTU, MDU_MULT: {hi_o, lo_o} = prod;
      MDU_MADDU, MDU_MADD: {hi_o, lo_o} = acc + prod;
      MDU_MSUBU, MDU_MSUB: {hi_o, lo_o} = acc - prod;
      MDU_DIVU,  MDU_DIV: begin
        upd_o = |b_i;
        hi_o  = r_s;
        lo_o  = q_s;
      end
      default: upd_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// Module      : mdu_unit
// Description : Multi-cycle multiply/divide unit with HI/LO registers,
//               per-class latency, accumulate ops, MTHI/MTLO writes and
//               exception cancel.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH   = MDU_WIDTH_DEF,
  parameter int MUL_LAT = MDU_MUL_LAT_DEF,
  parameter int DIV_LAT = MDU_DIV_LAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  mdu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             write,
  input  logic             addr,
  input  logic             cancel,
  output logic [WIDTH-1:0] rdata,
  output logic             busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  mdu_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  mdu_op_t          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             res_upd;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op_i  (op_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .hi_i  (hi_q),
    .lo_i  (lo_q),
    .hi_o  (res_hi),
    .lo_o  (res_lo),
    .upd_o (res_upd)
  );

  // Next-state: IDLE accepts writes and launches; RUN counts down, commits on
  // the last count, or abandons on cancel. Inputs are ignored while running.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (write) begin
          if (addr) lo_d = a;
          else      hi_d = a;
        end
        if (start && !cancel) begin
          state_d = S_RUN;
          op_d    = op;
          a_d     = a;
          b_d     = b;
          cnt_d   = is_div(op) ? DIV_CNT : MUL_CNT;
        end
      end
      S_RUN: begin
        if (cancel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_ONE) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (res_upd) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= MDU_MULTU;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign rdata = addr ? lo_q : hi_q;
  assign busy  = (state_q == S_RUN);

endmodule
`default_nettype wire
